// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM encoding and lane-slice helpers for the systolic feed path
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Default width of one operand lane (one ROM byte)
    localparam int LANE_SLICE_W = 8;

    // Bit position of the least significant bit of lane 'lane' in a packed word
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - per-lane data+valid shift register used to skew operands
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tvalid,
    output logic [DATA_WIDTH-1:0] skew_tdata,
    output logic                  skew_tvalid,
    output logic                  busy
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign skew_tdata  = tdata;
            assign skew_tvalid = tvalid;
            assign busy        = 1'b0;
        end else begin : g_shift
            logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
            logic [DEPTH-1:0]                 valid_q;

            // Shift data and valid one slot per cycle; empty slots carry zero data
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= '0;
                end else begin
                    data_q[0]  <= tvalid ? tdata : '0;
                    valid_q[0] <= tvalid;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign skew_tdata  = data_q[DEPTH-1];
            assign skew_tvalid = valid_q[DEPTH-1];
            assign busy        = |valid_q;
        end
    endgenerate

endmodule

// File: rtl/rom_skew_feeder.sv
// rtl/rom_skew_feeder.sv - ROM burst sequencer with diagonal operand skew for the systolic array
module rom_skew_feeder
    import systolic_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [CNT_WIDTH-1:0]            num_vec,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH*NUM_BANKS-1:0] rom_dout,
    output logic [DATA_WIDTH*NUM_BANKS-1:0] lane_data,
    output logic [NUM_BANKS-1:0]            lane_valid,
    output logic                            busy,
    output logic                            done
);

    localparam int                    WORD_W     = DATA_WIDTH * NUM_BANKS;
    localparam int                    DRAIN_W    = $clog2(NUM_BANKS + 2);
    // Cycles from entering DRAIN until the deepest lane has shown the last vector
    localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(NUM_BANKS + 1);
    // An empty burst still holds busy for one DRAIN cycle before done
    localparam logic [DRAIN_W-1:0]    DRAIN_ZERO = DRAIN_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(NUM_BANKS);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);

    fsm_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   vec_idx_q, vec_idx_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic                   issue_q, issue_d;
    logic                   rd_valid_q;
    logic [WORD_W-1:0]      stage0_data_q;
    logic                   stage0_valid_q;
    logic [NUM_BANKS-1:0]   lane_busy;
    logic                   pipes_empty;

    assign rom_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);

    assign pipes_empty = !issue_q && !rd_valid_q && !stage0_valid_q
                         && !(|lane_busy) && !(|lane_valid);

    // FSM, address counter, vector counter and drain counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            vec_idx_q <= '0;
            num_q     <= '0;
            drain_q   <= '0;
            issue_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            vec_idx_q <= vec_idx_d;
            num_q     <= num_d;
            drain_q   <= drain_d;
            issue_q   <= issue_d;
        end
    end

    // Next-state logic: accept a burst, issue one address per cycle, then drain the skew
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        vec_idx_d = vec_idx_q;
        num_d     = num_q;
        drain_d   = drain_q;
        issue_d   = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = base_addr;
                    num_d     = num_vec;
                    vec_idx_d = '0;
                    if (num_vec == '0) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_ZERO;
                    end else begin
                        issue_d = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (vec_idx_q == num_q - CNT_ONE) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    addr_d    = addr_q + ADDR_STEP;
                    vec_idx_d = vec_idx_q + CNT_ONE;
                    issue_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q != '0) begin
                    drain_d = drain_q - DRAIN_W'(1);
                end else if (pipes_empty) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Follow the ROM read latency and capture its output into stage 0 only for issued reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q     <= 1'b0;
            stage0_valid_q <= 1'b0;
            stage0_data_q  <= '0;
        end else begin
            rd_valid_q     <= issue_q;
            stage0_valid_q <= rd_valid_q;
            stage0_data_q  <= rd_valid_q ? rom_dout : '0;
        end
    end

    // Lane k is delayed k cycles behind stage 0; lane 0 is taken straight from stage 0
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_lane
        localparam int LSB = lane_lsb(k, DATA_WIDTH);
        if (k == 0) begin : g_direct
            assign lane_data[LSB +: DATA_WIDTH] = stage0_data_q[LSB +: DATA_WIDTH];
            assign lane_valid[k]                = stage0_valid_q;
            assign lane_busy[k]                 = 1'b0;
        end else begin : g_skew
            skew_delay_line #(
                .DEPTH      (k),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skew (
                .clk         (clk),
                .rst_n       (rst_n),
                .tdata       (stage0_data_q[LSB +: DATA_WIDTH]),
                .tvalid      (stage0_valid_q),
                .skew_tdata  (lane_data[LSB +: DATA_WIDTH]),
                .skew_tvalid (lane_valid[k]),
                .busy        (lane_busy[k])
            );
        end
    end

endmodule

// File: tb/tb_rom_skew_feeder.sv
// tb/tb_rom_skew_feeder.sv - directed self-checking bench for rom_skew_feeder
module tb_rom_skew_feeder;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int NB = 16;
    localparam int CW = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [CW-1:0]     num_vec;
    logic [AW-1:0]     rom_addr;
    logic [DW*NB-1:0]  rom_dout;
    logic [DW*NB-1:0]  lane_data;
    logic [NB-1:0]     lane_valid;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0]    obs_addr  [64];
    logic [DW*NB-1:0] obs_data  [64];
    logic [NB-1:0]    obs_valid [64];
    int               done_cnt;
    int               done_at;
    int               busy_cnt;
    int               valid0_cnt;
    int               any_valid_cnt;

    rom_skew_feeder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BANKS  (NB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_vec    (num_vec),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with mem[j] = j & 0xFF: word at address a holds byte (a+k) in lane k
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            rom_dout[k*DW +: DW] <= DW'(int'(rom_addr) + k);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one burst, sampling every cycle at the falling edge; t counts cycles after E0
    task automatic run_burst(input int base, input int n, input bit hold, input int abort_t);
        int done_t;
        int last;
        logic [NB-1:0]    ev;
        logic [DW*NB-1:0] ed;
        logic [AW-1:0]    ea;
        done_t        = (n == 0) ? 1 : n + NB + 1;
        last          = (abort_t >= 0) ? abort_t : done_t + 2;
        done_cnt      = 0;
        done_at       = -1;
        busy_cnt      = 0;
        valid0_cnt    = 0;
        any_valid_cnt = 0;
        @(negedge clk);
        base_addr = AW'(base);
        num_vec   = CW'(n);
        start     = 1'b1;
        @(posedge clk);
        for (int t = 0; t <= last; t++) begin
            @(negedge clk);
            obs_addr[t]  = rom_addr;
            obs_data[t]  = lane_data;
            obs_valid[t] = lane_valid;
            if (done) begin
                done_cnt++;
                done_at = t;
            end
            if (busy) busy_cnt++;
            if (lane_valid[0]) valid0_cnt++;
            if (|lane_valid) any_valid_cnt++;
            if (abort_t >= 0 && t == abort_t) begin
                check_eq("rst_valid", 128'(lane_valid), 128'(0));
                check_eq("rst_data", 128'(lane_data), 128'(0));
                check_eq("rst_busy", 128'(busy), 128'(0));
                check_eq("rst_done", 128'(done), 128'(0));
                check_eq("rst_addr", 128'(rom_addr), 128'(0));
                rst_n = 1'b1;
            end else begin
                ev = '0;
                ed = '0;
                for (int k = 0; k < NB; k++) begin
                    int i;
                    i = t - 2 - k;
                    if (i >= 0 && i < n) begin
                        ev[k]          = 1'b1;
                        ed[k*DW +: DW] = DW'(base + i * NB + k);
                    end
                end
                ea = AW'(base + NB * ((t < n) ? t : ((n > 0) ? n - 1 : 0)));
                check_eq($sformatf("valid_t%0d", t), 128'(lane_valid), 128'(ev));
                check_eq($sformatf("data_t%0d", t), 128'(lane_data), 128'(ed));
                check_eq($sformatf("addr_t%0d", t), 128'(rom_addr), 128'(ea));
                check_eq($sformatf("done_t%0d", t), 128'(done), 128'(t == done_t));
                check_eq($sformatf("busy_t%0d", t), 128'(busy), 128'(t <= done_t));
            end
            start = hold && (t < done_t);
            if (abort_t >= 0 && t == abort_t - 1) rst_n = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        int late_done;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_vec   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_addr", 128'(rom_addr), 128'(0));
        check_eq("reset_valid", 128'(lane_valid), 128'(0));
        check_eq("reset_data", 128'(lane_data), 128'(0));
        check_eq("reset_busy", 128'(busy), 128'(0));
        check_eq("reset_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single vector from address 0
        run_burst(0, 1, 1'b0, -1);
        check_eq("t1_addr0", 128'(obs_addr[0]), 128'(0));
        check_eq("t1_lane3_val", 128'(obs_data[5][3*DW +: DW]), 128'(3));
        check_eq("t1_lane3_vld", 128'(obs_valid[5]), 128'(16'h0008));
        check_eq("t1_lane15_val", 128'(obs_data[17][15*DW +: DW]), 128'(15));
        check_eq("t1_lane15_early", 128'(obs_valid[16][15]), 128'(0));
        check_eq("t1_done_at", 128'(done_at), 128'(18));
        check_eq("t1_done_cnt", 128'(done_cnt), 128'(1));

        // Three vectors from address 32
        run_burst(32, 3, 1'b0, -1);
        check_eq("t2_addr0", 128'(obs_addr[0]), 128'(32));
        check_eq("t2_addr1", 128'(obs_addr[1]), 128'(48));
        check_eq("t2_addr2", 128'(obs_addr[2]), 128'(64));
        check_eq("t2_lane5_a", 128'(obs_data[7][5*DW +: DW]), 128'(37));
        check_eq("t2_lane5_b", 128'(obs_data[8][5*DW +: DW]), 128'(53));
        check_eq("t2_lane5_c", 128'(obs_data[9][5*DW +: DW]), 128'(69));
        check_eq("t2_done_at", 128'(done_at), 128'(20));

        // Empty burst
        run_burst(100, 0, 1'b0, -1);
        check_eq("t3_any_valid", 128'(any_valid_cnt), 128'(0));
        check_eq("t3_done_at", 128'(done_at), 128'(1));
        check_eq("t3_busy_cycles", 128'(busy_cnt), 128'(2));

        // Start held high throughout a four-vector burst
        run_burst(64, 4, 1'b1, -1);
        check_eq("t4_done_cnt", 128'(done_cnt), 128'(1));
        check_eq("t4_last_addr", 128'(obs_addr[4]), 128'(112));
        check_eq("t4_final_addr", 128'(obs_addr[23]), 128'(112));
        check_eq("t4_vectors", 128'(valid0_cnt), 128'(4));

        // Reset at E0+5 of an eight-vector burst, then a fresh burst
        run_burst(0, 8, 1'b0, 5);
        late_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || (|lane_valid) || busy) late_done++;
        end
        check_eq("t5_quiet_after_rst", 128'(late_done), 128'(0));
        run_burst(16, 1, 1'b0, -1);
        check_eq("t5_restart_lane0", 128'(obs_data[2][DW-1:0]), 128'(16));
        check_eq("t5_restart_vld", 128'(obs_valid[2]), 128'(16'h0001));

        // Address wrap at the top of the address space
        run_burst((1 << AW) - 16, 2, 1'b0, -1);
        check_eq("t6_addr0", 128'(obs_addr[0]), 128'(496));
        check_eq("t6_addr_wrap", 128'(obs_addr[1]), 128'(0));
        check_eq("t6_lane0_a", 128'(obs_data[2][DW-1:0]), 128'(240));
        check_eq("t6_lane0_b", 128'(obs_data[3][DW-1:0]), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
